// File: rtl/latency_meter_pkg.sv
// Shared definitions for the latency meter: state encodings and state type.
package latency_meter_pkg;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_LAUNCH = 2'd1;
  localparam logic [1:0] STATE_WAIT   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = STATE_IDLE,
    S_LAUNCH = STATE_LAUNCH,
    S_WAIT   = STATE_WAIT
  } state_t;

endpackage

// File: rtl/latency_meter.sv
// Launches a one-cycle pulse into a path under test and counts the clock
// edges until its echo returns, reporting a timeout if the echo never comes.
module latency_meter
  import latency_meter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             echo,
  output logic             launch,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cycles,
  output logic             timeout,
  output logic             error
);

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  state_t           state;
  logic [WIDTH-1:0] count;

  // Measurement FSM: every output is a register; done/timeout/error/launch
  // default low each cycle so they can only ever pulse for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      launch  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cycles  <= '0;
      timeout <= 1'b0;
      error   <= 1'b0;
    end else begin
      launch  <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      error   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (echo) begin
              // Echo already high means the path cannot be measured.
              done   <= 1'b1;
              error  <= 1'b1;
              cycles <= '0;
            end else begin
              state  <= S_LAUNCH;
              launch <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          if (echo) begin
            cycles <= '0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            count <= WIDTH'(1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (echo) begin
            cycles <= count;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else if (count == TIMEOUT_W) begin
            cycles  <= TIMEOUT_W;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            count <= count + WIDTH'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latency_meter.sv
// Bench for latency_meter: drives the echo through selectable paths
// (loopback, delay line, tied low/high) and scoreboards each result.
module tb_latency_meter;

  localparam int W  = 8;
  localparam int TO = 10;

  typedef struct {
    logic [W-1:0] cyc;
    logic         to;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         echo;
  logic         launch;
  logic         busy;
  logic         done;
  logic [W-1:0] cycles;
  logic         timeout;
  logic         error;

  // echo_mode: 0 loopback, 1 delay line of delay_d flops, 2 tied low, 3 tied high
  int           echo_mode = 2;
  int           delay_d   = 1;
  logic [15:0]  launch_sr;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   launch_count = 0;
  int   launch_run = 0;
  int   launch_max_run = 0;
  int   done_count = 0;
  logic launch_prev = 1'b0;

  latency_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .echo(echo),
    .launch(launch), .busy(busy), .done(done), .cycles(cycles),
    .timeout(timeout), .error(error)
  );

  always #5 clk = ~clk;

  // Delay line standing in for the path under test.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) launch_sr <= '0;
    else       launch_sr <= {launch_sr[14:0], launch};
  end

  // Echo path selection.
  always_comb begin
    echo = 1'b0;
    case (echo_mode)
      0:       echo = launch;
      1:       echo = launch_sr[delay_d-1];
      2:       echo = 1'b0;
      default: echo = 1'b1;
    endcase
  end

  // Pulse statistics, sampled at the rising edge so they never race the tasks.
  always @(posedge clk) begin
    if (launch && !launch_prev) launch_count++;
    if (launch) launch_run++;
    else launch_run = 0;
    if (launch_run > launch_max_run) launch_max_run = launch_run;
    launch_prev = launch;
    if (done) done_count++;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    start = 1'b0;
    echo_mode = 2;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({launch, busy, done, cycles, timeout, error} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %b required all zero",
               {launch, busy, done, cycles, timeout, error});
    end
    reset = 1'b0;
    @(negedge clk);
    e = '{cyc: 0, to: 0, err: 0};
    e.cyc = 0;
  endtask

  task automatic test_delay3();
    exp_t e;
    bit   got;
    int   lc;
    echo_mode = 1;
    delay_d = 3;
    lc = launch_count;
    sb.push_back('{cyc: W'(3), to: 1'b0, err: 1'b0});
    pulse_start();
    wait_done(30, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("[TB] FAIL delay3_done: got no done required done within 30 cycles");
    end else begin
      e = sb.pop_front();
      if ({cycles, timeout, error} !== {e.cyc, e.to, e.err}) begin
        n_bad++;
        $display("[TB] FAIL delay3_result: got cyc=%0d to=%b err=%b required cyc=%0d to=%b err=%b",
                 cycles, timeout, error, e.cyc, e.to, e.err);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL delay3_busy: got %b required 0", busy);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (launch_count - lc !== 1) begin
      n_bad++;
      $display("[TB] FAIL delay3_launches: got %0d required 1", launch_count - lc);
    end
  endtask

  task automatic test_loopback();
    exp_t e;
    bit   got;
    echo_mode = 0;
    sb.push_back('{cyc: W'(0), to: 1'b0, err: 1'b0});
    pulse_start();
    wait_done(30, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("[TB] FAIL loopback_done: got no done required done within 30 cycles");
    end else begin
      e = sb.pop_front();
      if ({cycles, timeout, error} !== {e.cyc, e.to, e.err}) begin
        n_bad++;
        $display("[TB] FAIL loopback_result: got cyc=%0d to=%b err=%b required cyc=%0d to=%b err=%b",
                 cycles, timeout, error, e.cyc, e.to, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_flop();
    exp_t e;
    bit   got;
    echo_mode = 1;
    delay_d = 1;
    sb.push_back('{cyc: W'(1), to: 1'b0, err: 1'b0});
    pulse_start();
    wait_done(30, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("[TB] FAIL flop_done: got no done required done within 30 cycles");
    end else begin
      e = sb.pop_front();
      if ({cycles, timeout, error} !== {e.cyc, e.to, e.err}) begin
        n_bad++;
        $display("[TB] FAIL flop_result: got cyc=%0d to=%b err=%b required cyc=%0d to=%b err=%b",
                 cycles, timeout, error, e.cyc, e.to, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n;
    bit   got;
    echo_mode = 2;
    sb.push_back('{cyc: W'(TO), to: 1'b1, err: 1'b0});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("[TB] FAIL timeout_done: got no done required done within 40 cycles");
    end else begin
      e = sb.pop_front();
      if ({cycles, timeout, error} !== {e.cyc, e.to, e.err}) begin
        n_bad++;
        $display("[TB] FAIL timeout_result: got cyc=%0d to=%b err=%b required cyc=%0d to=%b err=%b",
                 cycles, timeout, error, e.cyc, e.to, e.err);
      end
      n_cmp++;
      if (n !== TO + 1) begin
        n_bad++;
        $display("[TB] FAIL timeout_latency: got %0d cycles after launch required %0d", n, TO + 1);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({done, timeout} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL timeout_pulse: got done=%b timeout=%b required 0 0", done, timeout);
    end
  endtask

  task automatic test_echo_error();
    exp_t e;
    bit   got;
    int   lc;
    echo_mode = 3;
    lc = launch_count;
    sb.push_back('{cyc: W'(0), to: 1'b0, err: 1'b1});
    pulse_start();
    wait_done(10, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("[TB] FAIL error_done: got no done required done within 10 cycles");
    end else begin
      e = sb.pop_front();
      if ({cycles, timeout, error, busy} !== {e.cyc, e.to, e.err, 1'b0}) begin
        n_bad++;
        $display("[TB] FAIL error_result: got cyc=%0d to=%b err=%b busy=%b required cyc=%0d to=%b err=%b busy=0",
                 cycles, timeout, error, busy, e.cyc, e.to, e.err);
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (launch_count - lc !== 0) begin
      n_bad++;
      $display("[TB] FAIL error_no_launch: got %0d launches required 0", launch_count - lc);
    end
    echo_mode = 2;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   got;
    int   lc;
    int   ok;
    echo_mode = 1;
    delay_d = 2;
    lc = launch_count;
    launch_max_run = 0;
    ok = 0;
    for (int k = 0; k < 4; k++) sb.push_back('{cyc: W'(2), to: 1'b0, err: 1'b0});
    @(negedge clk) start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wait_done(20, got);
      n_cmp++;
      if (!got) begin
        n_bad++;
        $display("[TB] FAIL b2b_done%0d: got no done required done within 20 cycles", k);
        break;
      end
      e = sb.pop_front();
      if ({cycles, timeout, error} !== {e.cyc, e.to, e.err}) begin
        n_bad++;
        $display("[TB] FAIL b2b_result%0d: got cyc=%0d to=%b err=%b required cyc=%0d to=%b err=%b",
                 k, cycles, timeout, error, e.cyc, e.to, e.err);
      end
      ok++;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (launch_count - lc !== 4) begin
      n_bad++;
      $display("[TB] FAIL b2b_launches: got %0d required 4", launch_count - lc);
    end
    n_cmp++;
    if (launch_max_run !== 1) begin
      n_bad++;
      $display("[TB] FAIL b2b_launch_width: got %0d cycles required 1", launch_max_run);
    end
    while (sb.size() > ok - ok && sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    bit   got;
    int   dc;
    echo_mode = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL midwait_busy: got %b required 1", busy);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({launch, busy, done, cycles, timeout, error} !== '0) begin
      n_bad++;
      $display("[TB] FAIL midwait_reset_outputs: got %b required all zero",
               {launch, busy, done, cycles, timeout, error});
    end
    @(negedge clk) reset = 1'b0;
    dc = done_count;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (done_count !== dc) begin
      n_bad++;
      $display("[TB] FAIL midwait_no_done: got %0d dones required 0", done_count - dc);
    end
    echo_mode = 1;
    delay_d = 3;
    sb.push_back('{cyc: W'(3), to: 1'b0, err: 1'b0});
    pulse_start();
    wait_done(30, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("[TB] FAIL post_reset_done: got no done required done within 30 cycles");
    end else begin
      e = sb.pop_front();
      if ({cycles, timeout, error} !== {e.cyc, e.to, e.err}) begin
        n_bad++;
        $display("[TB] FAIL post_reset_result: got cyc=%0d to=%b err=%b required cyc=%0d to=%b err=%b",
                 cycles, timeout, error, e.cyc, e.to, e.err);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_delay3();
    test_loopback();
    test_flop();
    test_timeout();
    test_echo_error();
    test_back_to_back();
    test_reset_mid_wait();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_empty: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
